// File: rtl/switch_debounce.sv
// Purpose: synchronise, debounce and edge-detect N_SW slide switches; latch change events until acked.
// Latency: a level held from sampling edge E0 is accepted at edge E(DEBOUNCE_CYCLES+1); pulses last one cycle.
// Backpressure: none on the pins; evt_valid/evt_mask stay sticky until evt_ack, later changes OR in.
module switch_debounce #(
    parameter int N_SW            = 16,
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES)
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic [N_SW-1:0] sw_raw,
    output logic [N_SW-1:0] sw_stable,
    output logic [N_SW-1:0] sw_rise,
    output logic [N_SW-1:0] sw_fall,
    output logic            evt_valid,
    output logic [N_SW-1:0] evt_mask,
    input  logic            evt_ack
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [N_SW-1:0]  sync1;
    logic [N_SW-1:0]  sync2;
    logic [CNT_W-1:0] cnt [N_SW];
    logic [N_SW-1:0]  chg;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= sw_raw;
            sync2 <= sync1;
        end
    end

    // Any return to the accepted level before the count completes restarts it.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sw_stable <= '0;
            sw_rise   <= '0;
            sw_fall   <= '0;
            for (int i = 0; i < N_SW; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            sw_rise <= '0;
            sw_fall <= '0;
            for (int i = 0; i < N_SW; i++) begin
                if (sync2[i] == sw_stable[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == CNT_MAX) begin
                    cnt[i]       <= '0;
                    sw_stable[i] <= sync2[i];
                    sw_rise[i]   <= sync2[i];
                    sw_fall[i]   <= ~sync2[i];
                end else begin
                    cnt[i] <= cnt[i] + CNT_W'(1);
                end
            end
        end
    end

    assign chg = sw_rise | sw_fall;

    // An ack coinciding with a new change keeps that change pending.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            evt_valid <= 1'b0;
            evt_mask  <= '0;
        end else if (evt_ack) begin
            evt_valid <= |chg;
            evt_mask  <= chg;
        end else begin
            evt_valid <= evt_valid | (|chg);
            evt_mask  <= evt_mask | chg;
        end
    end

endmodule
